// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Package     : aes_pkg
// Description : AES-128 shared types, forward S-box table and GF(2^8) helpers
//               used by the encrypt_round datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  // 128-bit AES state; byte 0 lives in bits [127:120], column-major order.
  typedef logic [127:0] aes_state_t;

  // Forward AES substitution box.
  localparam logic [7:0] AES_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Forward S-box lookup.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return AES_SBOX[x];
  endfunction

  // Multiply by 2 in GF(2^8), reducing by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by 3 in GF(2^8).
  function automatic logic [7:0] gmul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

  // Extract byte idx (0..15) of a state; byte 0 is the most significant.
  function automatic logic [7:0] get_byte(input aes_state_t s, input int unsigned idx);
    return s[127 - 8*idx -: 8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_mix_column.sv
`default_nettype none
// ============================================================================
// Module      : aes_mix_column
// Description : Combinational AES MixColumns on one 32-bit column.
//               col_i[31:24] is row 0 of the column, col_i[7:0] is row 3.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_mix_column
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col_i[31:24];
  assign a1 = col_i[23:16];
  assign a2 = col_i[15:8];
  assign a3 = col_i[7:0];

  // Fixed circulant matrix {2,3,1,1} applied row by row.
  assign col_o[31:24] = xtime(a0) ^ gmul3(a1) ^ a2        ^ a3;
  assign col_o[23:16] = a0        ^ xtime(a1) ^ gmul3(a2) ^ a3;
  assign col_o[15:8]  = a0        ^ a1        ^ xtime(a2) ^ gmul3(a3);
  assign col_o[7:0]   = gmul3(a0) ^ a1        ^ a2        ^ xtime(a3);

endmodule
`default_nettype wire

// File: rtl/encrypt_round.sv
`default_nettype none
// ============================================================================
// Module      : encrypt_round
// Description : One registered AES-128 encryption round
//               (SubBytes -> ShiftRows -> MixColumns -> AddRoundKey),
//               one round per clock. Reset is asynchronous, active-high
//               on rst_n despite its name.
// Options     : ENCRYPT_ROUND_FINAL_EN adds a final_round input that
//               bypasses MixColumns for the last AES round.
// Revision    : 1.0 - initial release
// ============================================================================
module encrypt_round
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] state,
  input  logic [127:0] key,
`ifdef ENCRYPT_ROUND_FINAL_EN
  input  logic         final_round,
`endif
  output logic [127:0] out
);

  aes_state_t shifted;   // SubBytes followed by ShiftRows
  aes_state_t mixed;     // MixColumns of shifted
  aes_state_t round_res; // value before key addition
  aes_state_t out_d;
  aes_state_t out_q;

  // SubBytes and ShiftRows merged: output (row r, col c) takes input (row r, col c+r mod 4).
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign shifted[127 - 8*(4*c + r) -: 8] = sbox(get_byte(state, 4*((c + r) % 4) + r));
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    aes_mix_column u_mix (
      .col_i (shifted[127 - 32*c -: 32]),
      .col_o (mixed[127 - 32*c -: 32])
    );
  end

`ifdef ENCRYPT_ROUND_FINAL_EN
  // The last AES round omits MixColumns.
  assign round_res = final_round ? shifted : mixed;
`else
  assign round_res = mixed;
`endif

  assign out_d = round_res ^ key;

  // Output register; clears immediately on reset.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule
`default_nettype wire

// File: tb/tb_encrypt_round.sv
`default_nettype none
// ============================================================================
// Module      : tb_encrypt_round
// Description : Self-checking bench for encrypt_round. Known-answer table,
//               reset sequences, and random rounds against a reference
//               model that derives the S-box from GF(2^8) inversion.
// Options     : ENCRYPT_ROUND_FINAL_EN exercises the final_round port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_encrypt_round;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] state = '0;
  logic [127:0] key = '0;
  logic [127:0] out;
`ifdef ENCRYPT_ROUND_FINAL_EN
  logic         final_round = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  encrypt_round dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .state       (state),
    .key         (key),
`ifdef ENCRYPT_ROUND_FINAL_EN
    .final_round (final_round),
`endif
    .out         (out)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0] ref_sbox [256];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      ref_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_round(input logic [127:0] s, input logic [127:0] k, input bit fin);
    logic [7:0] m [4][4];
    logic [7:0] t [4][4];
    logic [7:0] u [4][4];
    int coef [4][4] = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};
    logic [127:0] res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        m[r][c] = ref_sbox[s[127 - 8*(4*c + r) -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[r][c] = m[r][(c + r) % 4];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        u[r][c] = 8'h00;
        for (int j = 0; j < 4; j++) u[r][c] = u[r][c] ^ gf_mul(8'(coef[r][j]), t[j][c]);
        if (fin) u[r][c] = t[r][c];
      end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127 - 8*(4*c + r) -: 8] = u[r][c];
    return res ^ k;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %032h expected %032h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [127:0] s, input logic [127:0] k, input bit fin);
    state = s;
    key   = k;
`ifdef ENCRYPT_ROUND_FINAL_EN
    final_round = fin;
`else
    if (fin) $display("note: final_round requested in a build without it");
`endif
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  typedef struct {
    string        name;
    logic [127:0] st;
    logic [127:0] k;
    bit           fin;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] C1_ST  = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] C1_KEY = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] C1_OUT = 128'h89d810e8855ace682d1843d8cb128fe4;
  localparam logic [127:0] ZR_OUT = 128'h63636363636363636363636363636363;

  initial begin
    vec_t tbl [$];
    logic [127:0] rs, rk;
    bit           rf;

    build_sbox();

    tbl.push_back('{"c1_round1", C1_ST, C1_KEY, 1'b0, C1_OUT});
    tbl.push_back('{"all_zero", 128'h0, 128'h0, 1'b0, ZR_OUT});
    tbl.push_back('{"zero_state_key_ff", 128'h0, {16{8'hff}}, 1'b0, ~ZR_OUT});
`ifdef ENCRYPT_ROUND_FINAL_EN
    tbl.push_back('{"final_c1_round10", 128'h7ad5fda789ef4e272bca100b3d9ff59f,
                    128'h13111d7fe3944a17f307a78b4d2b30c5, 1'b1,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a});
    tbl.push_back('{"final_flag_off", C1_ST, C1_KEY, 1'b0, C1_OUT});
`endif

    // Reset: asserted between edges, output clears without a clock.
    drive(rnd128(), rnd128(), 1'b0);
    #1 rst_n = 1'b1;
    #1 check("reset_async", out, 128'h0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      drive(rnd128(), rnd128(), 1'b0);
      check("reset_hold", out, 128'h0);
    end
    rst_n = 1'b0;

    // Known-answer table, each with one-cycle latency.
    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].k, tbl[i].fin);
      @(posedge clk); #1;
      check(tbl[i].name, out, tbl[i].exp);
    end

    // Model sanity against the known answer, then back-to-back ordering.
    check("model_c1", ref_round(C1_ST, C1_KEY, 1'b0), C1_OUT);
    drive(C1_ST, C1_KEY, 1'b0);
    @(posedge clk); #1;
    check("b2b_first", out, C1_OUT);
    drive(128'h0, 128'h0, 1'b0);
    @(posedge clk); #1;
    check("b2b_second", out, ZR_OUT);

    // Mid-stream reset: clears at once, samples under reset are discarded.
    drive(C1_ST, C1_KEY, 1'b0);
    @(posedge clk); #1;
    check("pre_reset", out, C1_OUT);
    #2 rst_n = 1'b1;
    #1 check("midstream_async", out, 128'h0);
    @(posedge clk); #1;
    check("midstream_hold", out, 128'h0);
    rst_n = 1'b0;
    drive(128'h0, 128'h0, 1'b0);
    @(posedge clk); #1;
    check("post_reset_round", out, ZR_OUT);

    // Random back-to-back rounds against the model.
    for (int i = 0; i < 300; i++) begin
      rs = rnd128();
      rk = rnd128();
`ifdef ENCRYPT_ROUND_FINAL_EN
      rf = ($urandom_range(0, 3) == 0);
`else
      rf = 1'b0;
`endif
      drive(rs, rk, rf);
      @(posedge clk); #1;
      check("random_round", out, ref_round(rs, rk, rf));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
